// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_DEFAULT = 32'h00000013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } fetch_state_e;

  // Byte address of lane k; wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [1:0]        k);
    return base + ADDR_W'(k);
  endfunction

endpackage

// File: rtl/fetch_stage_byte_asm.sv
// Instruction assembly register: little-endian byte-lane writes, reloadable with NOP.
module fetch_stage_byte_asm
  import fetch_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load_nop,
  input  logic              i_wr_en,
  input  logic [1:0]        i_lane,
  input  logic [7:0]        i_byte,
  output logic [INST_W-1:0] o_inst
);

  logic [INST_W-1:0] r_inst;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_inst <= NOP_INST;
    end else if (i_load_nop) begin
      r_inst <= NOP_INST;
    end else if (i_wr_en) begin
      r_inst[{i_lane, 3'b000} +: 8] <= i_byte;
    end
  end

  assign o_inst = r_inst;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: four byte reads per PC, assembled into a 32-bit instruction,
// with downstream stall, redirect flush and misaligned-PC flagging.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST    = NOP_DEFAULT,
  parameter bit                CHECK_ALIGN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              misalign_o
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [1:0]        r_k;
  logic [1:0]        w_k_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_misalign;
  logic              w_xfer;
  logic              w_misalign_in;
  logic              w_wr_byte;
  logic              w_load_nop;

  // A new PC is taken when idle, or when the held output is consumed this cycle.
  assign pc_ready_o    = !flush_i && ((r_state == ST_IDLE) ||
                                      ((r_state == ST_DONE) && !stall_i));
  assign w_xfer        = pc_valid_i && pc_ready_o;
  assign w_misalign_in = CHECK_ALIGN && (pc_i[1:0] != 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_wr_byte   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) w_state_nxt = w_misalign_in ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (mem_gnt_i)    w_state_nxt = flush_i ? ST_DRAIN : ST_WAIT;
        else if (flush_i) w_state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          if (flush_i) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_wr_byte = 1'b1;
            if (r_k == 2'd3) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_k_nxt     = r_k + 2'd1;
              w_state_nxt = ST_REQ;
            end
          end
        end else if (flush_i) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush_i)       w_state_nxt = ST_IDLE;
        else if (!stall_i) w_state_nxt = w_xfer ? (w_misalign_in ? ST_DONE : ST_REQ) : ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_rvalid_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_xfer) w_k_nxt = 2'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_k        <= 2'd0;
      r_pc       <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_xfer) begin
        r_pc       <= pc_i;
        r_misalign <= w_misalign_in;
      end else if (flush_i) begin
        r_misalign <= 1'b0;
      end
    end
  end

  // Every new fetch and every flush starts from NOP so a misaligned PC presents NOP.
  assign w_load_nop = w_xfer || flush_i;

  fetch_stage_byte_asm #(
    .NOP_INST (NOP_INST)
  ) u_byte_asm (
    .clock      (clock),
    .reset      (reset),
    .i_load_nop (w_load_nop),
    .i_wr_en    (w_wr_byte),
    .i_lane     (r_k),
    .i_byte     (mem_rdata_i),
    .o_inst     (inst_o)
  );

  assign mem_req_o    = (r_state == ST_REQ);
  assign mem_addr_o   = mem_req_o ? byte_addr(r_pc, r_k) : '0;
  assign inst_valid_o = (r_state == ST_DONE);
  assign inst_pc_o    = r_pc;
  assign misalign_o   = r_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a byte-wide memory responder of configurable latency.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        pc_ready_o;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i;
  logic        mem_rvalid_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        misalign_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  mem [0:63];
  logic        gnt_en = 1'b1;
  int          rv_delay = 0;
  logic        pend;
  int          rv_cnt;
  logic [5:0]  paddr;
  int          n_gnt;
  logic [31:0] last_gnt_addr;

  fetch_stage #(.NOP_INST(32'h00000013), .CHECK_ALIGN(1'b1)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .pc_ready_o   (pc_ready_o),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .misalign_o   (misalign_o)
  );

  always #5 clock = ~clock;

  assign mem_gnt_i = mem_req_o && gnt_en;

  // Memory responder: rvalid arrives rv_delay cycles after the cycle following gnt.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_rvalid_i  <= 1'b0;
      mem_rdata_i   <= 8'h00;
      pend          <= 1'b0;
      rv_cnt        <= 0;
      paddr         <= '0;
      n_gnt         <= 0;
      last_gnt_addr <= '0;
    end else begin
      mem_rvalid_i <= 1'b0;
      if (mem_req_o && mem_gnt_i) begin
        n_gnt         <= n_gnt + 1;
        last_gnt_addr <= mem_addr_o;
        if (rv_delay == 0) begin
          mem_rvalid_i <= 1'b1;
          mem_rdata_i  <= mem[mem_addr_o[5:0]];
        end else begin
          pend   <= 1'b1;
          rv_cnt <= rv_delay - 1;
          paddr  <= mem_addr_o[5:0];
        end
      end else if (pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid_i <= 1'b1;
          mem_rdata_i  <= mem[paddr];
          pend         <= 1'b0;
        end else begin
          rv_cnt <= rv_cnt - 1;
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] pc);
    int w = 0;
    while (!pc_ready_o && w < 50) begin
      @(negedge clock);
      w++;
    end
    pc_i       = pc;
    pc_valid_i = 1'b1;
    @(negedge clock);
    pc_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!inst_valid_o && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic wait_req_addr(input logic [31:0] a);
    int w = 0;
    while (!(mem_req_o && mem_addr_o == a) && w < 40) begin
      @(negedge clock);
      w++;
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    n_chk++;
    if ({inst_valid_o, misalign_o, mem_req_o, inst_pc_o, mem_addr_o, inst_o} !==
        {3'b000, 32'h0, 32'h0, 32'h00000013})
      $display("FAIL reset_outputs got v=%b m=%b r=%b pc=%h a=%h i=%h want 0 0 0 0 0 00000013",
               inst_valid_o, misalign_o, mem_req_o, inst_pc_o, mem_addr_o, inst_o);
    else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_chk++;
    if (pc_ready_o !== 1'b1) $display("FAIL reset_idle_ready got %b want 1", pc_ready_o);
    else n_pass++;
  endtask

  task automatic test_basic_fetch;
    int cyc;
    do_fetch(32'h0);
    wait_valid(cyc);
    n_chk++;
    if (cyc !== 8) $display("FAIL basic_latency got %0d want 8", cyc);
    else n_pass++;
    n_chk++;
    if ({inst_valid_o, inst_o, inst_pc_o, misalign_o} !== {1'b1, 32'h00100513, 32'h0, 1'b0})
      $display("FAIL basic_output got v=%b i=%h pc=%h m=%b want 1 00100513 00000000 0",
               inst_valid_o, inst_o, inst_pc_o, misalign_o);
    else n_pass++;
    @(negedge clock);
    n_chk++;
    if (inst_valid_o !== 1'b0) $display("FAIL basic_consumed got %b want 0", inst_valid_o);
    else n_pass++;
  endtask

  task automatic test_stall;
    int cyc;
    stall_i = 1'b1;
    do_fetch(32'h0);
    wait_valid(cyc);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({inst_valid_o, pc_ready_o, mem_req_o, inst_o, inst_pc_o} !==
          {3'b100, 32'h00100513, 32'h0})
        $display("FAIL stall_hold%0d got v=%b rdy=%b req=%b i=%h pc=%h want 1 0 0 00100513 00000000",
                 i, inst_valid_o, pc_ready_o, mem_req_o, inst_o, inst_pc_o);
      else n_pass++;
      @(negedge clock);
    end
    stall_i = 1'b0;
    #1;
    n_chk++;
    if (pc_ready_o !== 1'b1) $display("FAIL stall_release_ready got %b want 1", pc_ready_o);
    else n_pass++;
    pc_i       = 32'h4;
    pc_valid_i = 1'b1;
    @(negedge clock);
    pc_valid_i = 1'b0;
    n_chk++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h4})
      $display("FAIL stall_next_req got req=%b a=%h want 1 00000004", mem_req_o, mem_addr_o);
    else n_pass++;
    wait_valid(cyc);
    n_chk++;
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h00100093, 32'h4})
      $display("FAIL stall_next_inst got v=%b i=%h pc=%h want 1 00100093 00000004",
               inst_valid_o, inst_o, inst_pc_o);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_flush_wait;
    int   cyc;
    logic seen_valid;
    rv_delay = 2;
    do_fetch(32'h4);
    wait_req_addr(32'h5);
    @(negedge clock);
    flush_i = 1'b1;
    @(negedge clock);
    flush_i = 1'b0;
    n_chk++;
    if ({pc_ready_o, inst_valid_o, inst_o} !== {2'b00, 32'h00000013})
      $display("FAIL flush_drain got rdy=%b v=%b i=%h want 0 0 00000013",
               pc_ready_o, inst_valid_o, inst_o);
    else n_pass++;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (inst_valid_o) seen_valid = 1'b1;
    end
    n_chk++;
    if ({seen_valid, pc_ready_o, mem_req_o} !== 3'b010)
      $display("FAIL flush_discard got valid_seen=%b rdy=%b req=%b want 0 1 0",
               seen_valid, pc_ready_o, mem_req_o);
    else n_pass++;
    rv_delay = 0;
    do_fetch(32'h8);
    wait_valid(cyc);
    n_chk++;
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h00200113, 32'h8})
      $display("FAIL flush_refetch got v=%b i=%h pc=%h want 1 00200113 00000008",
               inst_valid_o, inst_o, inst_pc_o);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_misalign;
    int cyc;
    int g;
    g = n_gnt;
    do_fetch(32'h6);
    wait_valid(cyc);
    n_chk++;
    if (cyc !== 0) $display("FAIL misalign_latency got %0d want 0", cyc);
    else n_pass++;
    n_chk++;
    if ({inst_valid_o, misalign_o, mem_req_o, inst_o, inst_pc_o} !==
        {3'b110, 32'h00000013, 32'h6})
      $display("FAIL misalign_output got v=%b m=%b req=%b i=%h pc=%h want 1 1 0 00000013 00000006",
               inst_valid_o, misalign_o, mem_req_o, inst_o, inst_pc_o);
    else n_pass++;
    @(negedge clock);
    n_chk++;
    if (n_gnt !== g) $display("FAIL misalign_no_mem got %0d grants want %0d", n_gnt, g);
    else n_pass++;
  endtask

  task automatic test_gnt_hold;
    int cyc;
    do_fetch(32'h10);
    wait_req_addr(32'h12);
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_chk++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h12})
        $display("FAIL gnt_hold%0d got req=%b a=%h want 1 00000012", i, mem_req_o, mem_addr_o);
      else n_pass++;
    end
    gnt_en = 1'b1;
    wait_valid(cyc);
    n_chk++;
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h003101b3, 32'h10})
      $display("FAIL gnt_hold_inst got v=%b i=%h pc=%h want 1 003101b3 00000010",
               inst_valid_o, inst_o, inst_pc_o);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_wait;
    int cyc;
    rv_delay = 2;
    do_fetch(32'h14);
    wait_req_addr(32'h15);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_chk++;
    if ({inst_valid_o, misalign_o, mem_req_o, inst_pc_o, mem_addr_o, inst_o} !==
        {3'b000, 32'h0, 32'h0, 32'h00000013})
      $display("FAIL reset_mid_wait got v=%b m=%b r=%b pc=%h a=%h i=%h want 0 0 0 0 0 00000013",
               inst_valid_o, misalign_o, mem_req_o, inst_pc_o, mem_addr_o, inst_o);
    else n_pass++;
    @(negedge clock);
    reset    = 1'b1;
    rv_delay = 0;
    @(negedge clock);
    do_fetch(32'h14);
    wait_valid(cyc);
    n_chk++;
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h40520233, 32'h14})
      $display("FAIL reset_refetch got v=%b i=%h pc=%h want 1 40520233 00000014",
               inst_valid_o, inst_o, inst_pc_o);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_wrap;
    int cyc;
    do_fetch(32'hFFFFFFFC);
    wait_valid(cyc);
    n_chk++;
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h0000006f, 32'hFFFFFFFC})
      $display("FAIL wrap_inst got v=%b i=%h pc=%h want 1 0000006f fffffffc",
               inst_valid_o, inst_o, inst_pc_o);
    else n_pass++;
    n_chk++;
    if (last_gnt_addr !== 32'hFFFFFFFF)
      $display("FAIL wrap_last_addr got %h want ffffffff", last_gnt_addr);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_flush_priority;
    int cyc;
    stall_i = 1'b1;
    do_fetch(32'h8);
    wait_valid(cyc);
    flush_i = 1'b1;
    #1;
    n_chk++;
    if (pc_ready_o !== 1'b0) $display("FAIL flush_stall_ready got %b want 0", pc_ready_o);
    else n_pass++;
    @(negedge clock);
    n_chk++;
    if ({inst_valid_o, inst_o} !== {1'b0, 32'h00000013})
      $display("FAIL flush_over_stall got v=%b i=%h want 0 00000013", inst_valid_o, inst_o);
    else n_pass++;
    stall_i    = 1'b0;
    pc_i       = 32'h0;
    pc_valid_i = 1'b1;
    #1;
    n_chk++;
    if (pc_ready_o !== 1'b0) $display("FAIL flush_idle_ready got %b want 0", pc_ready_o);
    else n_pass++;
    @(negedge clock);
    flush_i    = 1'b0;
    pc_valid_i = 1'b0;
    n_chk++;
    if (mem_req_o !== 1'b0) $display("FAIL flush_idle_no_accept got req=%b want 0", mem_req_o);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    {mem[0],  mem[1],  mem[2],  mem[3]}  = {8'h13, 8'h05, 8'h10, 8'h00};
    {mem[4],  mem[5],  mem[6],  mem[7]}  = {8'h93, 8'h00, 8'h10, 8'h00};
    {mem[8],  mem[9],  mem[10], mem[11]} = {8'h13, 8'h01, 8'h20, 8'h00};
    {mem[16], mem[17], mem[18], mem[19]} = {8'hb3, 8'h01, 8'h31, 8'h00};
    {mem[20], mem[21], mem[22], mem[23]} = {8'h33, 8'h02, 8'h52, 8'h40};
    {mem[60], mem[61], mem[62], mem[63]} = {8'h6f, 8'h00, 8'h00, 8'h00};

    test_reset;
    test_basic_fetch;
    test_stall;
    test_flush_wait;
    test_misalign;
    test_gnt_hold;
    test_reset_mid_wait;
    test_wrap;
    test_flush_priority;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
